// File: rtl/pop_serial_tx.sv
// ---------------------------------------------------------------------------
// pop_serial_tx
// Drains a valid/grant FIFO pop port and sends each word as an asynchronous
// serial frame: start bit (0), DATA_WIDTH data bits LSB first, an optional
// even-parity bit, then STOP_BITS stop bits (1). The line idles high.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable_i     permits acceptance of new words
//   pop_valid_i  upstream FIFO has a word
//   pop_data_i   upstream word (captured on the accepting edge)
//   pop_grant_o  block accepts a word this cycle (IDLE && enable_i)
//   tx_o         registered serial line, idle high
//   busy_o       frame in progress
//   frame_cnt_o  number of frames fully sent, wraps at 16 bits
// ---------------------------------------------------------------------------
module pop_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  pop_valid_i,
    input  logic [DATA_WIDTH-1:0] pop_data_i,
    output logic                  pop_grant_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             USE_PAR   = (PARITY_EN == 1) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_stop_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic [15:0]           r_frame_cnt;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_bit_end;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Even parity: the XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Grant comes from registered state only; reset_n forces it low at once.
    assign w_grant      = (r_state == S_IDLE) && enable_i && reset_n;
    assign w_accept     = w_grant && pop_valid_i;
    assign w_bit_end    = (r_cnt == CNT_ZERO);
    assign w_shift_next = r_shift >> 1;

    assign pop_grant_o  = w_grant;
    assign tx_o         = r_tx;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_cnt_o  = r_frame_cnt;

    // Frame sequencer: tx is loaded together with each state change so the
    // line level for a bit period is already registered when the period starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_ZERO;
            r_bit_idx   <= IDX_ZERO;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_START;
                        r_cnt    <= CNT_LOAD;
                        r_shift  <= pop_data_i;
                        r_parity <= even_parity(pop_data_i);
                        r_tx     <= 1'b0;
                    end else begin
                        r_tx     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_cnt     <= CNT_LOAD;
                        r_bit_idx <= IDX_ZERO;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_cnt     <= r_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_bit_idx == IDX_LAST) begin
                            if (USE_PAR) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= S_STOP;
                                r_stop_idx <= 1'b0;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_ONE;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_cnt      <= CNT_LOAD;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_state     <= S_IDLE;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_cnt      <= CNT_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pop_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_pop_serial_tx
// Two instances: u0 with defaults (F=40) and u1 with parity, two stop bits
// and 3 clocks per bit (F=36). Each is fed from its own bench FIFO with
// random gaps, random enable toggling and occasional mid-frame resets. A
// reference model tracks only "cycles since accept" per instance and derives
// the expected line level arithmetically from the frame layout.
// ---------------------------------------------------------------------------
module tb_pop_serial_tx;

    localparam int CPB0 = 4;
    localparam int F0   = (1 + 8 + 0 + 1) * CPB0;
    localparam int CPB1 = 3;
    localparam int F1   = (1 + 8 + 1 + 2) * CPB1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [7:0]  d0 = 8'd0, d1 = 8'd0;
    logic        g0, g1, tx0, tx1, b0, b1;
    logic [15:0] c0, c1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_age0 = 0, m_age1 = 0;
    logic [7:0]  m_data0 = 8'd0, m_data1 = 8'd0;
    logic [15:0] m_cnt0 = 16'd0, m_cnt1 = 16'd0;
    logic [7:0]  fq0[$];
    logic [7:0]  fq1[$];

    always #5 clk = ~clk;

    pop_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB0), .STOP_BITS(1), .PARITY_EN(0)) u0 (
        .clk(clk), .reset_n(reset_n), .enable_i(en), .pop_valid_i(v0), .pop_data_i(d0),
        .pop_grant_o(g0), .tx_o(tx0), .busy_o(b0), .frame_cnt_o(c0)
    );

    pop_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB1), .STOP_BITS(2), .PARITY_EN(1)) u1 (
        .clk(clk), .reset_n(reset_n), .enable_i(en), .pop_valid_i(v1), .pop_data_i(d1),
        .pop_grant_o(g1), .tx_o(tx1), .busy_o(b1), .frame_cnt_o(c1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected line level `age` cycles after the accepting edge (age 1..F).
    function automatic logic exp_line(input logic [7:0] data, input int age,
                                      input int cpb, input bit par_en);
        int slot;
        slot = (age - 1) / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return data[slot-1];
        if (par_en && slot == 9) return ^data;
        return 1'b1;
    endfunction

    task automatic check_all();
        chk("tx0",    {15'd0, tx0}, {15'd0, (m_age0 == 0) ? 1'b1 : exp_line(m_data0, m_age0, CPB0, 1'b0)});
        chk("busy0",  {15'd0, b0},  {15'd0, (m_age0 != 0)});
        chk("grant0", {15'd0, g0},  {15'd0, (m_age0 == 0) && en && reset_n});
        chk("cnt0",   c0, m_cnt0);
        chk("tx1",    {15'd0, tx1}, {15'd0, (m_age1 == 0) ? 1'b1 : exp_line(m_data1, m_age1, CPB1, 1'b1)});
        chk("busy1",  {15'd0, b1},  {15'd0, (m_age1 != 0)});
        chk("grant1", {15'd0, g1},  {15'd0, (m_age1 == 0) && en && reset_n});
        chk("cnt1",   c1, m_cnt1);
    endtask

    // Model update at the active edge; inputs are stable here (driven on negedge).
    always @(posedge clk) begin
        if (reset_n) begin
            if (m_age0 != 0) begin
                if (m_age0 == F0) begin m_age0 = 0; m_cnt0 = m_cnt0 + 16'd1; end
                else m_age0 = m_age0 + 1;
            end else if (en && v0) begin
                m_age0 = 1; m_data0 = d0; void'(fq0.pop_front());
            end
            if (m_age1 != 0) begin
                if (m_age1 == F1) begin m_age1 = 0; m_cnt1 = m_cnt1 + 16'd1; end
                else m_age1 = m_age1 + 1;
            end else if (en && v1) begin
                m_age1 = 1; m_data1 = d1; void'(fq1.pop_front());
            end
        end
    end

    initial begin
        fq0 = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'hF0};
        fq1 = '{8'h07, 8'h03};
        // reset held with enable and valid high
        reset_n = 1'b0; en = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h5A; d1 = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        reset_n = 1'b1;
        v0 = 1'b1; d0 = fq0[0];
        v1 = 1'b1; d1 = fq1[0];
        #1;
        check_all();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            check_all();
            if (!reset_n) begin
                reset_n = 1'b1;
                #1;
                check_all();
            end else if (cyc > 100 && $urandom_range(499) == 0) begin
                // asynchronous reset in the middle of the cycle
                reset_n = 1'b0;
                m_age0 = 0; m_cnt0 = 16'd0;
                m_age1 = 0; m_cnt1 = 16'd0;
                #1;
                check_all();
            end
            if ($urandom_range(39) == 0) en = ~en;
            if (cyc > 300 && fq0.size() < 2) fq0.push_back(8'($urandom));
            if (cyc > 300 && fq1.size() < 2) fq1.push_back(8'($urandom));
            v0 = (fq0.size() > 0) && ($urandom_range(3) != 0);
            d0 = v0 ? fq0[0] : 8'($urandom);
            v1 = (fq1.size() > 0) && ($urandom_range(3) != 0);
            d1 = v1 ? fq1[0] : 8'($urandom);
            // data on the bus wanders freely while a frame is in flight
            if (m_age0 != 0) d0 = 8'($urandom);
            if (m_age1 != 0) d1 = 8'($urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
